// File: rtl/brute_force.sv
// Odometer-style password candidate generator for exhaustive search, 1..16 chars.
// Optional macro BRUTE_FORCE_DIGITS_EN extends the alphabet with '0'..'9'.
module brute_force (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [7:0]   startingPosition,
  input  logic [2:0]   increment,
  output logic [7:0]   wordLength,
  output logic [127:0] password,
  output logic         done
);

`ifdef BRUTE_FORCE_DIGITS_EN
  localparam logic [5:0] LastIdx = 6'd35;
`else
  localparam logic [5:0] LastIdx = 6'd25;
`endif

  // Indices 0..25 map to 'a'..'z', 26..35 map to '0'..'9'.
  function automatic logic [7:0] toAscii(input logic [5:0] idx);
    return (idx < 6'd26) ? 8'h61 + 8'(idx) : 8'h16 + 8'(idx);
  endfunction

  logic [5:0]   symIdx [16];
  logic [5:0]   nextIdx [16];
  logic [5:0]   startIdx;
  logic [5:0]   resetStart;
  logic [2:0]   stride;
  logic [4:0]   len;
  logic [4:0]   nextLen;
  logic         nextDone;
  logic         carry;
  logic [6:0]   sum;
  logic [127:0] nextPw;
  logic [127:0] resetPw;

  always_comb begin
    resetStart = 6'd0;
    if (startingPosition >= 8'h61 && startingPosition <= 8'h7a)
      resetStart = 6'(startingPosition - 8'h61);
`ifdef BRUTE_FORCE_DIGITS_EN
    else if (startingPosition >= 8'h30 && startingPosition <= 8'h39)
      resetStart = 6'(startingPosition - 8'h16);
`endif
    resetPw = {120'd0, toAscii(resetStart)};
  end

  // Character 0 strides by K and falls back to S; higher characters ripple by one.
  always_comb begin
    nextIdx  = symIdx;
    nextLen  = len;
    nextDone = done;
    carry    = 1'b0;
    sum      = 7'(symIdx[0]) + 7'(stride);
    if (sum <= 7'(LastIdx)) begin
      nextIdx[0] = sum[5:0];
    end else begin
      nextIdx[0] = startIdx;
      carry      = 1'b1;
    end
    for (int i = 1; i < 16; i++) begin
      if (carry && (5'(i) < len)) begin
        if (symIdx[i] < LastIdx) begin
          nextIdx[i] = symIdx[i] + 6'd1;
          carry      = 1'b0;
        end else begin
          nextIdx[i] = 6'd0;
        end
      end
    end
    if (carry) begin
      if (len < 5'd16) begin
        nextIdx[len[3:0]] = 6'd0;
        nextLen           = len + 5'd1;
      end else begin
        nextIdx  = symIdx;
        nextDone = 1'b1;
      end
    end
    nextPw = '0;
    for (int i = 0; i < 16; i++) begin
      if (5'(i) < nextLen)
        nextPw[8*i +: 8] = toAscii(nextIdx[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      startIdx <= resetStart;
      stride   <= (increment == 3'd0) ? 3'd1 : increment;
      for (int i = 0; i < 16; i++)
        symIdx[i] <= (i == 0) ? resetStart : 6'd0;
      len      <= 5'd1;
      done     <= 1'b0;
      password <= resetPw;
    end else if (enable && !done) begin
      symIdx   <= nextIdx;
      len      <= nextLen;
      done     <= nextDone;
      password <= nextPw;
    end
  end

  assign wordLength = {3'd0, len};

endmodule

// File: tb/tb_brute_force.sv
// Scoreboard bench for brute_force: an ASCII-level reference model pushes expectations,
// popped and compared one cycle after each driven edge.
module tb_brute_force;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic [7:0]   spIn;
  logic [2:0]   incIn;
  logic [7:0]   wordLength;
  logic [127:0] password;
  logic         done;

  int testsRun = 0;
  int failCount = 0;

  typedef struct packed {
    logic [7:0]   len;
    logic [127:0] pw;
    logic         done;
  } expT;

  expT sb[$];

  logic [7:0] mChars [16];
  logic [7:0] mS;
  int         mK;
  int         mLen;
  logic       mDone;

  brute_force dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .startingPosition(spIn),
    .increment(incIn),
    .wordLength(wordLength),
    .password(password),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    testsRun++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic validSym(input logic [7:0] c);
`ifdef BRUTE_FORCE_DIGITS_EN
    if (c >= "0" && c <= "9") return 1'b1;
`endif
    return (c >= "a" && c <= "z");
  endfunction

  // Returns {wrapped, successor symbol}.
  function automatic logic [8:0] succ(input logic [7:0] c);
`ifdef BRUTE_FORCE_DIGITS_EN
    if (c == "z") return {1'b0, 8'h30};
    if (c == "9") return {1'b1, 8'h61};
`else
    if (c == "z") return {1'b1, 8'h61};
`endif
    return {1'b0, c + 8'd1};
  endfunction

  task automatic modelStep(input logic en, input logic rn);
    logic [7:0] t [16];
    logic [8:0] r;
    logic       carry;
    logic [7:0] c;
    if (!rn) begin
      mS    = validSym(spIn) ? spIn : 8'h61;
      mK    = (incIn == 3'd0) ? 1 : int'(incIn);
      mLen  = 1;
      mDone = 1'b0;
      for (int i = 0; i < 16; i++) mChars[i] = 8'h00;
      mChars[0] = mS;
    end else if (en && !mDone) begin
      t = mChars;
      carry = 1'b0;
      c = t[0];
      for (int k = 0; k < mK; k++) begin
        r = succ(c);
        c = r[7:0];
        if (r[8]) carry = 1'b1;
      end
      t[0] = carry ? mS : c;
      for (int i = 1; i < mLen; i++) begin
        if (carry) begin
          r = succ(t[i]);
          t[i] = r[7:0];
          carry = r[8];
        end
      end
      if (carry) begin
        if (mLen < 16) begin
          t[mLen] = 8'h61;
          mLen++;
          mChars = t;
        end else begin
          mDone = 1'b1;
        end
      end else begin
        mChars = t;
      end
    end
  endtask

  function automatic expT packModel();
    expT e;
    e.len  = 8'(mLen);
    e.done = mDone;
    e.pw   = '0;
    for (int i = 0; i < 16; i++) e.pw[8*i +: 8] = mChars[i];
    return e;
  endfunction

  task automatic applyStimulus(input logic en, input logic rn);
    expT e;
    enable = en;
    rst_n  = rn;
    modelStep(en, rn);
    sb.push_back(packModel());
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checkOutput("len", 128'(wordLength), 128'(e.len));
    checkOutput("pw", password, e.pw);
    checkOutput("done", 128'(done), 128'(e.done));
  endtask

  initial begin
    enable = 1'b0;
    rst_n  = 1'b0;
    spIn   = "a";
    incIn  = 3'd1;

    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("resetPw", password, 128'h61);
    checkOutput("resetLen", 128'(wordLength), 128'd1);
    checkOutput("resetDone", 128'(done), 128'd0);

    for (int n = 1; n <= 702; n++) begin
      applyStimulus(1'b1, 1'b1);
`ifdef BRUTE_FORCE_DIGITS_EN
      if (n == 26) checkOutput("digit0", password, 128'h30);
      if (n == 35) checkOutput("digit9", password, 128'h39);
      if (n == 36) checkOutput("digitRoll", password, 128'h6161);
`else
      if (n == 25) checkOutput("rollZ", password, 128'h7A);
      if (n == 26) checkOutput("rollAa", password, 128'h6161);
      if (n == 26) checkOutput("rollLen2", 128'(wordLength), 128'd2);
      if (n == 702) checkOutput("rollAaa", password, 128'h616161);
      if (n == 702) checkOutput("rollLen3", 128'(wordLength), 128'd3);
`endif
    end

    for (int n = 0; n < 10; n++) applyStimulus(1'b0, 1'b1);
    for (int n = 0; n < 5; n++) applyStimulus(1'b1, 1'b1);

    spIn  = "b";
    incIn = 3'd3;
    applyStimulus(1'b0, 1'b0);
    checkOutput("strideReset", password, 128'h62);
    for (int n = 1; n <= 12; n++) begin
      if (n == 4) incIn = 3'd5;
      applyStimulus(1'b1, 1'b1);
`ifndef BRUTE_FORCE_DIGITS_EN
      if (n == 8) checkOutput("strideZ", password, 128'h7A);
      if (n == 9) checkOutput("strideAb", password, 128'h6162);
`endif
    end

    spIn  = "a";
    incIn = 3'd0;
    applyStimulus(1'b1, 1'b0);
    checkOutput("midReset", password, 128'h61);
    for (int n = 1; n <= 40; n++) begin
      applyStimulus(1'b1, 1'b1);
`ifndef BRUTE_FORCE_DIGITS_EN
      if (n == 26) checkOutput("incZeroAa", password, 128'h6161);
`endif
    end

    spIn  = "#";
    incIn = 3'd7;
    applyStimulus(1'b0, 1'b0);
    checkOutput("badStart", password, 128'h61);
    for (int n = 0; n < 10; n++) applyStimulus(1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
